// File: rtl/wb_arbiter_if.sv
// Wishbone classic bundle shared by the fetch unit, load/store unit and memory port.
// MASTER drives the request fields; SLAVE returns read data and ACK.
interface wishbone #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic [XLEN/8-1:0] sel;
  logic              we;
  logic              stb;
  logic              cyc;
  logic              ack;

  modport MASTER (output adr, dat_w, sel, we, stb, cyc, input dat_r, ack);
  modport SLAVE  (input adr, dat_w, sel, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter (instr = master 0, data = master 1) with a
// bus-hang watchdog that force-terminates unacknowledged transfers and flags the owner.
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  wishbone.SLAVE     instr_bus,
  wishbone.SLAVE     data_bus,
  wishbone.MASTER    mem_bus,
  output logic [1:0] grant,
  output logic       bus_err,
  output logic       err_src
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   adr;
    logic [XLEN-1:0]   dat_w;
    logic [XLEN/8-1:0] sel;
    logic              we;
    logic              stb;
    logic              cyc;
  } wb_req_t;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           bus_err_q, bus_err_d;
  logic           err_src_q, err_src_d;

  wb_req_t mi, md, own_req;
  logic    req_i, req_d, req_own, req_oth;
  logic    owning, own_sel, expire, done, end_own;

  assign mi = '{instr_bus.adr, instr_bus.dat_w, instr_bus.sel,
                instr_bus.we, instr_bus.stb, instr_bus.cyc};
  assign md = '{data_bus.adr, data_bus.dat_w, data_bus.sel,
                data_bus.we, data_bus.stb, data_bus.cyc};

  assign req_i = mi.cyc & mi.stb;
  assign req_d = md.cyc & md.stb;

  always_comb begin
    own_req = '0;
    owning  = 1'b0;
    own_sel = 1'b0;
    case (state_q)
      OWN_I: begin own_req = mi; owning = 1'b1; own_sel = 1'b0; end
      OWN_D: begin own_req = md; owning = 1'b1; own_sel = 1'b1; end
      default: ;
    endcase
  end

  assign req_own = own_sel ? req_d : req_i;
  assign req_oth = own_sel ? req_i : req_d;
  // A real ACK on the expiry cycle takes precedence over the forced one.
  assign expire  = owning && (wd_q == WDW'(TIMEOUT)) && !mem_bus.ack;
  assign done    = owning && (mem_bus.ack || expire);
  assign end_own = owning && (!own_req.cyc || (done && req_oth) || expire);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wd_d      = wd_q;
    bus_err_d = bus_err_q | expire;
    err_src_d = expire ? own_sel : err_src_q;

    case (state_q)
      IDLE: begin
        if (req_i && req_d) state_d = last_q ? OWN_I : OWN_D;
        else if (req_i)     state_d = OWN_I;
        else if (req_d)     state_d = OWN_D;
      end
      OWN_I, OWN_D: begin
        if (end_own) begin
          last_d = own_sel;
          if (req_oth)      state_d = own_sel ? OWN_I : OWN_D;
          else if (req_own) state_d = state_q;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Re-grant to the same master still counts as a fresh watchdog window.
    if (state_d != state_q || end_own || mem_bus.ack)
      wd_d = '0;
    else if (owning && own_req.stb && wd_q != WDW'(TIMEOUT))
      wd_d = wd_q + WDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      wd_q      <= '0;
      bus_err_q <= 1'b0;
      err_src_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
      err_src_q <= err_src_d;
    end
  end

  assign mem_bus.adr   = own_req.adr;
  assign mem_bus.dat_w = own_req.dat_w;
  assign mem_bus.sel   = own_req.sel;
  assign mem_bus.we    = own_req.we;
  assign mem_bus.stb   = own_req.stb & ~expire;
  assign mem_bus.cyc   = own_req.cyc & ~expire;

  assign instr_bus.ack   = (state_q == OWN_I) && done;
  assign data_bus.ack    = (state_q == OWN_D) && done;
  assign instr_bus.dat_r = ((state_q == OWN_I) && expire) ? '0 : mem_bus.dat_r;
  assign data_bus.dat_r  = ((state_q == OWN_D) && expire) ? '0 : mem_bus.dat_r;

  assign grant   = state_q;
  assign bus_err = bus_err_q;
  assign err_src = err_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT=4; the slave ACK and read data are
// driven straight from the stimulus so every cycle's expected values are fixed by hand.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  grant;
  logic        bus_err;
  logic        err_src;
  logic        slv_ack;
  logic [31:0] slv_dat;
  int          tests;
  int          fails;

  wishbone #(.XLEN(32)) ib ();
  wishbone #(.XLEN(32)) db ();
  wishbone #(.XLEN(32)) mb ();

  assign mb.ack   = slv_ack;
  assign mb.dat_r = slv_dat;

  wb_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_bus(ib),
    .data_bus (db),
    .mem_bus  (mb),
    .grant    (grant),
    .bus_err  (bus_err),
    .err_src  (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic c, input logic [31:0] a);
    ib.cyc = c; ib.stb = c; ib.we = 1'b0; ib.adr = a; ib.dat_w = '0; ib.sel = 4'hF;
  endtask

  task automatic set_d(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    db.cyc = c; db.stb = c; db.we = w; db.adr = a; db.dat_w = d; db.sel = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b0;
    slv_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_i(1'b1, 32'h10);
    set_d(1'b1, 1'b1, 32'h20, 32'h1);
    slv_ack = 1'b1;
    slv_dat = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b expected 00", grant); end
    tests++; if (bus_err !== 1'b0 || err_src !== 1'b0) begin fails++; $display("FAIL reset_err: got %b/%b expected 0/0", bus_err, err_src); end
    tests++; if ({mb.stb, mb.cyc, mb.we} !== 3'b000) begin fails++; $display("FAIL reset_mem_ctl: got %b expected 000", {mb.stb, mb.cyc, mb.we}); end
    tests++; if ({ib.ack, db.ack} !== 2'b00) begin fails++; $display("FAIL reset_acks: got %b expected 00", {ib.ack, db.ack}); end
    do_reset();
  endtask

  task automatic test_single();
    tick();
    set_i(1'b1, 32'h100);
    slv_ack = 1'b1;
    slv_dat = 32'hCAFE_0001;
    @(negedge clk);
    tests++; if (grant !== 2'b00 || ib.ack !== 1'b0) begin fails++; $display("FAIL single_req_cycle: got grant %b ack %b expected 00/0", grant, ib.ack); end
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b expected 01", grant); end
    tests++; if (ib.ack !== 1'b1 || db.ack !== 1'b0) begin fails++; $display("FAIL single_ack: got i%b d%b expected i1 d0", ib.ack, db.ack); end
    tests++; if (mb.adr !== 32'h100 || mb.cyc !== 1'b1) begin fails++; $display("FAIL single_mem_adr: got %h cyc %b expected 00000100 cyc 1", mb.adr, mb.cyc); end
    tests++; if (ib.dat_r !== 32'hCAFE_0001) begin fails++; $display("FAIL single_dat_r: got %h expected cafe0001", ib.dat_r); end
    tick();
    set_i(1'b0, '0);
    slv_ack = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b00 || mb.cyc !== 1'b0) begin fails++; $display("FAIL single_release: got grant %b cyc %b expected 00/0", grant, mb.cyc); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g [4];
    logic [1:0] got_a [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    do_reset();
    tick();
    set_i(1'b1, 32'h200);
    set_d(1'b1, 1'b1, 32'h300, 32'hD);
    slv_ack = 1'b1;
    slv_dat = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      got_a[k] = {db.ack, ib.ack};
      tests++; if (grant !== exp_g[k] || got_a[k] !== exp_g[k]) begin fails++; $display("FAIL tie_cycle%0d: got grant %b acks %b expected %b", k, grant, got_a[k], exp_g[k]); end
    end
    tests++; if (mb.adr !== 32'h200 || mb.we !== 1'b0) begin fails++; $display("FAIL tie_mux_instr: got %h we %b expected 00000200 we 0", mb.adr, mb.we); end
    tick();
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL tie_release: got %b expected 00", grant); end
  endtask

  task automatic test_stream();
    int  acks;
    logic bad;
    acks = 0;
    bad  = 1'b0;
    tick();
    set_i(1'b1, 32'h400);
    slv_ack = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k != 0) tick();
      @(negedge clk);
      if (ib.ack === 1'b1) acks++;
      if (k >= 1 && grant !== 2'b01) bad = 1'b1;
    end
    tests++; if (acks != 20) begin fails++; $display("FAIL stream_acks: got %0d expected 20", acks); end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL stream_grant: grant left 01 during stream, expected held"); end
    // data request lands mid-stream
    tick();
    set_d(1'b1, 1'b0, 32'h500, '0);
    @(negedge clk);
    tests++; if (grant !== 2'b01 || ib.ack !== 1'b1) begin fails++; $display("FAIL stream_preempt_now: got grant %b ack %b expected 01/1", grant, ib.ack); end
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b10 || db.ack !== 1'b1 || mb.adr !== 32'h500) begin fails++; $display("FAIL stream_preempt_next: got grant %b dack %b adr %h expected 10/1/00000500", grant, db.ack, mb.adr); end
    tick();
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL stream_release: got %b expected 00", grant); end
  endtask

  task automatic test_race();
    tick();
    set_d(1'b1, 1'b0, 32'h600, '0);
    slv_ack = 1'b0;
    slv_dat = 32'h1234_5678;
    for (int k = 1; k <= 4; k++) tick();
    tick();
    slv_ack = 1'b1;
    @(negedge clk);
    tests++; if (db.ack !== 1'b1 || db.dat_r !== 32'h1234_5678 || mb.stb !== 1'b1) begin fails++; $display("FAIL race_ack: got ack %b dat %h stb %b expected 1/12345678/1", db.ack, db.dat_r, mb.stb); end
    tick();
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (bus_err !== 1'b0 || grant !== 2'b00) begin fails++; $display("FAIL race_no_err: got err %b grant %b expected 0/00", bus_err, grant); end
  endtask

  task automatic test_watchdog();
    logic bad;
    bad = 1'b0;
    tick();
    set_d(1'b1, 1'b1, 32'h700, 32'h55);
    slv_ack = 1'b0;
    slv_dat = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) set_i(1'b1, 32'h800);
      @(negedge clk);
      if (db.ack !== 1'b0 || mb.stb !== 1'b1 || grant !== 2'b10) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL wd_wait: early ACK or lost grant before expiry, expected none"); end
    tick();
    @(negedge clk);
    tests++; if (db.ack !== 1'b1 || db.dat_r !== 32'h0) begin fails++; $display("FAIL wd_forced_ack: got ack %b dat %h expected 1/00000000", db.ack, db.dat_r); end
    tests++; if (mb.stb !== 1'b0 || mb.cyc !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL wd_expiry_bus: got stb %b cyc %b err %b expected 0/0/0", mb.stb, mb.cyc, bus_err); end
    tests++; if (ib.dat_r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wd_broadcast: got %h expected deadbeef", ib.dat_r); end
    tick();
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b1;
    @(negedge clk);
    tests++; if (bus_err !== 1'b1 || err_src !== 1'b1) begin fails++; $display("FAIL wd_err_flag: got %b/%b expected 1/1", bus_err, err_src); end
    tests++; if (grant !== 2'b01 || ib.ack !== 1'b1 || mb.adr !== 32'h800) begin fails++; $display("FAIL wd_handover: got grant %b ack %b adr %h expected 01/1/00000800", grant, ib.ack, mb.adr); end
    tick();
    set_i(1'b0, '0);
    slv_ack = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (bus_err !== 1'b1 || grant !== 2'b00) begin fails++; $display("FAIL wd_sticky: got err %b grant %b expected 1/00", bus_err, grant); end
  endtask

  task automatic test_reset_mid();
    tick();
    set_d(1'b1, 1'b0, 32'h900, '0);
    slv_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL rmid_owned: got %b expected 10", grant); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (grant !== 2'b00 || mb.cyc !== 1'b0 || bus_err !== 1'b0 || db.ack !== 1'b0) begin fails++; $display("FAIL rmid_async: got grant %b cyc %b err %b ack %b expected 00/0/0/0", grant, mb.cyc, bus_err, db.ack); end
    @(negedge clk);
    rst_n = 1'b1;
    set_i(1'b1, 32'hA00);
    slv_ack = 1'b1;
    tick();
    @(negedge clk);
    tests++; if (grant !== 2'b10 || db.ack !== 1'b1) begin fails++; $display("FAIL rmid_tie_after: got grant %b ack %b expected 10/1", grant, db.ack); end
    tick();
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    slv_ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_tie();
    test_stream();
    test_race();
    test_watchdog();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
